// File: rtl/lfsr_run_ctrl.sv
// rtl/lfsr_run_ctrl.sv - command sequencer driving load/step strobes of an LFSR datapath
//
// Accepts LOAD / RUN / STOP / NOP commands on a valid/ready handshake and
// turns them into lfsr_load / lfsr_step strobes for the external LFSR core.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   ena                 design enable; low freezes state and counters
//   cmd_valid/cmd_ready command handshake (cmd_ready is combinational)
//   cmd_op, cmd_arg     00 NOP, 01 LOAD (seed), 10 RUN (N, 0 = free-run), 11 STOP
//   lfsr_q              current datapath state
//   lfsr_load/lfsr_seed load strobe and seed for the datapath
//   lfsr_step           advance strobe for the datapath
//   busy, done, cmd_err status: busy in LOAD/RUN/DONE, end-of-run pulse, ignored-command pulse
//   step_cnt            steps issued since the last accepted RUN
//
// Optional build macro: LFSR_LOCKUP_RESEED_EN
//   When defined, a zero lfsr_q seen during RUN replaces the next step with a
//   reload of DEFAULT_SEED; that cycle is not counted as a step.

module lfsr_run_ctrl #(
  parameter int              WIDTH        = 8,
  parameter int              CNT_W        = 8,
  parameter logic [WIDTH-1:0] DEFAULT_SEED = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_arg,
  input  logic [WIDTH-1:0] lfsr_q,
  output logic             lfsr_load,
  output logic [WIDTH-1:0] lfsr_seed,
  output logic             lfsr_step,
  output logic             busy,
  output logic             done,
  output logic             cmd_err,
  output logic [CNT_W-1:0] step_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_LOAD = 2'b01;
  localparam logic [1:0] OP_RUN  = 2'b10;
  localparam logic [1:0] OP_STOP = 2'b11;

  state_t           state, state_d;
  logic [CNT_W-1:0] remaining, rem_d;
  logic [CNT_W-1:0] cnt_d;
  logic [WIDTH-1:0] seed_d;
  logic             load_d, step_d, done_d, err_d, busy_d;
  logic             last_step;
  logic             cmd_accept;

  assign cmd_ready  = ena && (state == S_IDLE || state == S_RUN);
  assign cmd_accept = cmd_valid && cmd_ready;

`ifndef LFSR_LOCKUP_RESEED_EN
  // lfsr_q only matters for lockup recovery.
  logic unused_lfsr_q;
  assign unused_lfsr_q = ^lfsr_q;
`endif

  always_comb begin
    state_d   = state;
    rem_d     = remaining;
    cnt_d     = step_cnt;
    seed_d    = lfsr_seed;
    load_d    = 1'b0;
    step_d    = 1'b0;
    done_d    = 1'b0;
    err_d     = 1'b0;
    last_step = 1'b0;

    if (ena) begin
      unique case (state)
        S_IDLE: begin
          if (cmd_accept) begin
            unique case (cmd_op)
              OP_LOAD: begin
                state_d = S_LOAD;
                load_d  = 1'b1;
                seed_d  = (cmd_arg[WIDTH-1:0] == '0) ? DEFAULT_SEED : cmd_arg[WIDTH-1:0];
              end
              OP_RUN: begin
                state_d = S_RUN;
                step_d  = 1'b1;
                cnt_d   = '0;
                rem_d   = cmd_arg;
              end
              OP_STOP: err_d = 1'b1;
              default: ;
            endcase
          end
        end

        S_LOAD: state_d = S_IDLE;

        S_RUN: begin
          // Accounting happens in the cycle the step strobe is high, so a
          // step that a STOP arrives alongside is still counted.
          if (lfsr_step) begin
            cnt_d = step_cnt + CNT_W'(1);
            // remaining == 0 means free-run: never decremented, never ends.
            if (remaining != '0) begin
              rem_d     = remaining - CNT_W'(1);
              last_step = (remaining == CNT_W'(1));
            end
          end

          if (cmd_accept && (cmd_op == OP_LOAD || cmd_op == OP_RUN)) begin
            err_d = 1'b1;
          end

          if (last_step || (cmd_accept && cmd_op == OP_STOP)) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
`ifdef LFSR_LOCKUP_RESEED_EN
            // Only reseed once; the datapath takes the seed at the end of
            // the load cycle, so lfsr_q may still read zero during it.
            if (lfsr_q == '0 && !lfsr_load) begin
              load_d = 1'b1;
              seed_d = DEFAULT_SEED;
            end else begin
              step_d = 1'b1;
            end
`else
            step_d = 1'b1;
`endif
          end
        end

        S_DONE: state_d = S_IDLE;

        default: state_d = S_IDLE;
      endcase
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      remaining <= '0;
      step_cnt  <= '0;
      lfsr_seed <= DEFAULT_SEED;
      lfsr_load <= 1'b0;
      lfsr_step <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cmd_err   <= 1'b0;
    end else begin
      state     <= state_d;
      remaining <= rem_d;
      step_cnt  <= cnt_d;
      lfsr_seed <= seed_d;
      lfsr_load <= load_d;
      lfsr_step <= step_d;
      busy      <= busy_d;
      done      <= done_d;
      cmd_err   <= err_d;
    end
  end

endmodule

// File: tb/tb_lfsr_run_ctrl.sv
// tb/tb_lfsr_run_ctrl.sv - self-checking bench for lfsr_run_ctrl
module tb_lfsr_run_ctrl;

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_LOAD = 2'b01;
  localparam logic [1:0] OP_RUN  = 2'b10;
  localparam logic [1:0] OP_STOP = 2'b11;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [7:0] cmd_arg = 8'h00;
  logic [7:0] lfsr_q = 8'hA5;
  logic       lfsr_load;
  logic [7:0] lfsr_seed;
  logic       lfsr_step;
  logic       busy;
  logic       done;
  logic       cmd_err;
  logic [7:0] step_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int mon_steps = 0;
  int mon_errs = 0;

  logic [7:0] seed_q[$];
  logic [7:0] done_q[$];

  typedef struct {
    logic [1:0] op;
    logic [7:0] arg;
    logic       exp_load;
    logic [7:0] exp_seed;
    logic       exp_err;
    logic       exp_busy;
  } vec_t;

  vec_t vecs[5];

  lfsr_run_ctrl #(.WIDTH(8), .CNT_W(8), .DEFAULT_SEED(8'h01)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_arg(cmd_arg),
    .lfsr_q(lfsr_q), .lfsr_load(lfsr_load), .lfsr_seed(lfsr_seed), .lfsr_step(lfsr_step),
    .busy(busy), .done(done), .cmd_err(cmd_err), .step_cnt(step_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [7:0] arg);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_arg   = arg;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op    = OP_NOP;
    cmd_arg   = 8'h00;
  endtask

  task automatic wait_done(input int budget, input string name);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check({name, "_done_seen"}, 32'(seen), 32'd1);
    @(posedge clk);
    #1;
  endtask

  // Scoreboard side: expected seeds / final counts are queued when the
  // stimulus is driven and consumed when the DUT raises load / done.
  always @(negedge clk) begin
    if (lfsr_load) begin
      if (seed_q.size() == 0) begin
        check("unexpected_load", 32'(lfsr_load), 32'd0);
      end else begin
        check("load_seed", 32'(lfsr_seed), 32'(seed_q.pop_front()));
      end
    end
    if (done) begin
      if (done_q.size() == 0) begin
        check("unexpected_done", 32'(done), 32'd0);
      end else begin
        check("done_step_cnt", 32'(step_cnt), 32'(done_q.pop_front()));
      end
    end
    if (lfsr_step && ena) mon_steps++;
    if (cmd_err) mon_errs++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{OP_LOAD, 8'h5A, 1'b1, 8'h5A, 1'b0, 1'b1};
    vecs[1] = '{OP_LOAD, 8'h00, 1'b1, 8'h01, 1'b0, 1'b1};
    vecs[2] = '{OP_LOAD, 8'hFF, 1'b1, 8'hFF, 1'b0, 1'b1};
    vecs[3] = '{OP_STOP, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[4] = '{OP_NOP,  8'h00, 1'b0, 8'h00, 1'b0, 1'b0};

    // Reset state
    ena = 1'b1;
    #23;
    @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_load",      32'(lfsr_load), 32'd0);
    check("rst_step",      32'(lfsr_step), 32'd0);
    check("rst_seed",      32'(lfsr_seed), 32'h01);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_done",      32'(done),      32'd0);
    check("rst_err",       32'(cmd_err),   32'd0);
    check("rst_cnt",       32'(step_cnt),  32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick(1);

    // Single commands from IDLE
    for (int i = 0; i < 5; i++) begin
      if (vecs[i].exp_load) seed_q.push_back(vecs[i].exp_seed);
      issue(vecs[i].op, vecs[i].arg);
      @(negedge clk);
      check($sformatf("vec%0d_load", i), 32'(lfsr_load), 32'(vecs[i].exp_load));
      check($sformatf("vec%0d_err", i),  32'(cmd_err),   32'(vecs[i].exp_err));
      check($sformatf("vec%0d_busy", i), 32'(busy),      32'(vecs[i].exp_busy));
      @(negedge clk);
      check($sformatf("vec%0d_load_once", i), 32'(lfsr_load), 32'd0);
      check($sformatf("vec%0d_idle", i),      32'(cmd_ready), 32'd1);
      @(posedge clk);
      #1;
    end
    check("idle_stop_err_count", 32'(mon_errs), 32'd1);

    // RUN N=5
    mon_steps = 0;
    done_q.push_back(8'd5);
    issue(OP_RUN, 8'd5);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      check($sformatf("run5_step_c%0d", k), 32'(lfsr_step), 32'(k <= 5));
      check($sformatf("run5_done_c%0d", k), 32'(done),      32'(k == 6));
      if (k == 7) check("run5_busy_after", 32'(busy), 32'd0);
    end
    @(posedge clk);
    #1;
    check("run5_steps", 32'(mon_steps), 32'd5);
    check("run5_cnt",   32'(step_cnt),  32'd5);

    // Free-run, LOAD ignored mid-run, STOP after 300 steps
    mon_steps = 0;
    mon_errs  = 0;
    issue(OP_RUN, 8'd0);
    tick(99);
    issue(OP_LOAD, 8'h33);
    @(negedge clk);
    check("free_load_err",   32'(cmd_err),   32'd1);
    check("free_still_step", 32'(lfsr_step), 32'd1);
    @(posedge clk);
    #1;
    tick(198);
    done_q.push_back(8'd44);
    issue(OP_STOP, 8'd0);
    @(negedge clk);
    check("free_done",     32'(done),      32'd1);
    check("free_cnt",      32'(step_cnt),  32'd44);
    check("free_step_off", 32'(lfsr_step), 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("free_busy_after", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    check("free_steps", 32'(mon_steps), 32'd300);
    check("free_errs",  32'(mon_errs),  32'd1);

    // ena low for 3 cycles during RUN N=10
    mon_steps = 0;
    done_q.push_back(8'd10);
    issue(OP_RUN, 8'd10);
    tick(2);
    ena = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("ena_low_ready_c%0d", k), 32'(cmd_ready), 32'd0);
      if (k > 0) check($sformatf("ena_low_step_c%0d", k), 32'(lfsr_step), 32'd0);
      @(posedge clk);
      #1;
    end
    ena = 1'b1;
    wait_done(40, "ena_run");
    check("ena_steps", 32'(mon_steps), 32'd10);

    // Zero datapath state during RUN N=4
    mon_steps = 0;
    done_q.push_back(8'd4);
`ifdef LFSR_LOCKUP_RESEED_EN
    seed_q.push_back(8'h01);
`endif
    issue(OP_RUN, 8'd4);
    tick(1);
    lfsr_q = 8'h00;
    tick(1);
    lfsr_q = 8'hA5;
    wait_done(20, "lockup");
    check("lockup_steps", 32'(mon_steps), 32'd4);
    check("lockup_cnt",   32'(step_cnt),  32'd4);

    // Asynchronous reset mid-run (N=200, after 50 steps)
    issue(OP_RUN, 8'd200);
    tick(49);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_step",  32'(lfsr_step), 32'd0);
    check("arst_busy",  32'(busy),      32'd0);
    check("arst_cnt",   32'(step_cnt),  32'd0);
    check("arst_done",  32'(done),      32'd0);
    check("arst_seed",  32'(lfsr_seed), 32'h01);
    check("arst_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1;
    tick(1);
    rst_n = 1'b1;
    tick(10);
    check("post_rst_busy", 32'(busy),     32'd0);
    check("post_rst_cnt",  32'(step_cnt), 32'd0);

    check("seed_q_empty", 32'(seed_q.size()), 32'd0);
    check("done_q_empty", 32'(done_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
